// File: rtl/har_bnn_pkg.sv
// Shared constants and FSM state type for the HAR BNN frame loader.
package har_bnn_pkg;

    localparam int FEAT_CNT   = 12;
    localparam int FEAT_BITS  = 4;
    localparam int IN_BITS    = 8;
    localparam int CLASS_CNT  = 6;
    localparam int SETTLE_CYC = 2;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } loader_state_t;

endpackage

// File: rtl/bnn_feat_quant.sv
// Raw sample to feature quantizer: truncation by default, round-half-up with
// saturation when QUANT_ROUND_EN is defined.
module bnn_feat_quant #(
    parameter int IN_BITS   = har_bnn_pkg::IN_BITS,
    parameter int FEAT_BITS = har_bnn_pkg::FEAT_BITS
) (
    input  logic [IN_BITS-1:0]   raw,
    output logic [FEAT_BITS-1:0] q
);

    // Bits below the kept field are intentionally dropped.
    logic unused_raw;
    assign unused_raw = ^raw;

`ifdef QUANT_ROUND_EN
    logic [FEAT_BITS:0] sum;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        sum = {1'b0, raw[IN_BITS-1 -: FEAT_BITS]} + {{FEAT_BITS{1'b0}}, raw[IN_BITS-FEAT_BITS-1]};
        q   = sum[FEAT_BITS] ? {FEAT_BITS{1'b1}} : sum[FEAT_BITS-1:0];
    end
`else
    assign q = raw[IN_BITS-1 -: FEAT_BITS];
`endif

endmodule

// File: rtl/har_bnn_frame_loader.sv
// Collects FEAT_CNT quantized samples into a feature vector, lets the external
// classifier settle, then hands the registered class downstream. Option: QUANT_ROUND_EN.
module har_bnn_frame_loader
    import har_bnn_pkg::*;
#(
    parameter int FEAT_CNT   = har_bnn_pkg::FEAT_CNT,
    parameter int FEAT_BITS  = har_bnn_pkg::FEAT_BITS,
    parameter int IN_BITS    = har_bnn_pkg::IN_BITS,
    parameter int CLASS_CNT  = har_bnn_pkg::CLASS_CNT,
    parameter int SETTLE_CYC = har_bnn_pkg::SETTLE_CYC
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [IN_BITS-1:0]            s_data,
    input  logic                          s_last,
    output logic [FEAT_CNT*FEAT_BITS-1:0] features,
    input  logic [$clog2(CLASS_CNT)-1:0]  prediction,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(CLASS_CNT)-1:0]  m_class,
    output logic                          frame_err
);

    localparam int IW = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    loader_state_t       state, state_nxt;
    logic [IW-1:0]       idx;
    logic [SW-1:0]       settle_cnt;
    logic [FEAT_BITS-1:0] q;
    logic                beat, at_end, last_ok, bad;

    bnn_feat_quant #(
        .IN_BITS  (IN_BITS),
        .FEAT_BITS(FEAT_BITS)
    ) u_quant (
        .raw(s_data),
        .q  (q)
    );

    assign s_ready = (state == FILL);
    assign beat    = s_valid && s_ready;
    assign at_end  = (idx == IW'(FEAT_CNT - 1));
    assign last_ok = beat && at_end && s_last;
    // A framing error is any disagreement between slot position and s_last.
    assign bad     = beat && (at_end != s_last);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (last_ok) state_nxt = SETTLE;
            SETTLE:  if (settle_cnt == '0) state_nxt = HOLD;
            HOLD:    if (m_valid && m_ready) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // NOTE: the feature vector is a plain register bank, so it is reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            settle_cnt <= '0;
            features   <= '0;
            m_class    <= '0;
            m_valid    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= bad;
            if (beat) begin
                idx <= (bad || at_end) ? '0 : idx + 1'b1;
                if (!bad) features[idx*FEAT_BITS +: FEAT_BITS] <= q;
                if (last_ok) settle_cnt <= SW'(SETTLE_CYC - 1);
            end
            if (state == SETTLE) begin
                if (settle_cnt == '0) begin
                    m_class <= prediction;
                    m_valid <= 1'b1;
                end else begin
                    settle_cnt <= settle_cnt - 1'b1;
                end
            end
            if (state == HOLD && m_ready) m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_har_bnn_frame_loader.sv
// Directed and randomized bench for har_bnn_frame_loader with a stub classifier
// and a frame-level reference model.
module tb_har_bnn_frame_loader;

    localparam int FEAT_CNT   = 12;
    localparam int FEAT_BITS  = 4;
    localparam int IN_BITS    = 8;
    localparam int CLASS_CNT  = 6;
    localparam int SETTLE_CYC = 2;
    localparam int CW         = 3;
    localparam int FW         = FEAT_CNT * FEAT_BITS;

    logic          clk = 1'b0;
    logic          rst, s_valid, s_ready, s_last, m_valid, m_ready, frame_err;
    logic [7:0]    s_data;
    logic [FW-1:0] features;
    logic [CW-1:0] prediction, m_class;
    logic          use_const;

    int n_asserts = 0;
    int n_fails   = 0;
    int exp_feat[FEAT_CNT];
    int exp_idx   = 0;

    always #5 clk = ~clk;

    // Stub classifier: constant 3, or sum of features modulo CLASS_CNT.
    function automatic logic [CW-1:0] stub_class(input logic [FW-1:0] f);
        int s = 0;
        for (int i = 0; i < FEAT_CNT; i++) s += int'(f[i*FEAT_BITS +: FEAT_BITS]);
        return CW'(s % CLASS_CNT);
    endfunction

    assign prediction = use_const ? CW'(3) : stub_class(features);

    har_bnn_frame_loader dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .features  (features),
        .prediction(prediction),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_class   (m_class),
        .frame_err (frame_err)
    );

    function automatic int quant(input int d);
        int v = d / 16;
`ifdef QUANT_ROUND_EN
        if ((d / 8) % 2 == 1) v = v + 1;
        if (v > 15) v = 15;
`endif
        return v;
    endfunction

    function automatic logic [FW-1:0] exp_vec();
        logic [FW-1:0] v = '0;
        for (int i = 0; i < FEAT_CNT; i++) v[i*FEAT_BITS +: FEAT_BITS] = FEAT_BITS'(exp_feat[i]);
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input int d, input bit last);
        int waited = 0;
        bit err = 0;
        s_valid = 1'b1;
        s_data  = 8'(d);
        s_last  = last;
        while (s_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        check("s_ready_wait", 64'(s_ready), 64'd1);
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'($urandom);
        if (exp_idx == FEAT_CNT - 1 && last) begin
            exp_feat[exp_idx] = quant(d);
            exp_idx = 0;
        end else if ((exp_idx == FEAT_CNT - 1) != last) begin
            err = 1;
            exp_idx = 0;
        end else begin
            exp_feat[exp_idx] = quant(d);
            exp_idx++;
        end
        check("frame_err", 64'(frame_err), 64'(err));
        if (err) begin
            tick();
            check("frame_err_pulse_end", 64'(frame_err), 64'd0);
            check("no_m_valid_after_err", 64'(m_valid), 64'd0);
        end
    endtask

    // fill < 0 gives random samples; last_at < 0 never raises s_last.
    task automatic send_frame(input int n, input int last_at, input int fill, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) tick($urandom_range(0, 2));
            send_beat((fill >= 0) ? fill : int'($urandom_range(0, 255)), i == last_at);
        end
    endtask

    // Entered one step after the edge that accepted the last beat.
    task automatic expect_result(input int bp_cycles);
        logic [FW-1:0] ev = exp_vec();
        logic [CW-1:0] ec = use_const ? CW'(3) : stub_class(ev);
        check("s_ready_drop", 64'(s_ready), 64'd0);
        check("features_done", 64'(features), 64'(ev));
        check("m_valid_early", 64'(m_valid), 64'd0);
        repeat (SETTLE_CYC - 1) begin
            tick();
            check("m_valid_early", 64'(m_valid), 64'd0);
        end
        tick();
        check("m_valid_set", 64'(m_valid), 64'd1);
        check("m_class", 64'(m_class), 64'(ec));
        check("features_held", 64'(features), 64'(ev));
        for (int k = 0; k < bp_cycles; k++) begin
            tick();
            check("bp_m_valid", 64'(m_valid), 64'd1);
            check("bp_m_class", 64'(m_class), 64'(ec));
            check("bp_features", 64'(features), 64'(ev));
            check("bp_s_ready", 64'(s_ready), 64'd0);
        end
        m_ready = 1'b1;
        tick();
        check("m_valid_clear", 64'(m_valid), 64'd0);
        check("s_ready_back", 64'(s_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] q18_exp;
`ifdef QUANT_ROUND_EN
        q18_exp = 4'h2;
`else
        q18_exp = 4'h1;
`endif
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1; use_const = 1'b1;
        tick(2);
        check("rst_features", 64'(features), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_class", 64'(m_class), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        rst = 1'b0;
        tick();

        // Nominal frame with constant-3 classifier.
        send_frame(12, 11, 8'hF0, 0);
        check("nominal_vector", 64'(features), 64'hFFFF_FFFF_FFFF);
        expect_result(0);

        // Quantization corner values in slots 0 and 1.
        use_const = 1'b0;
        send_beat(8'h18, 0);
        send_beat(8'hF8, 0);
        send_frame(10, 9, -1, 0);
        check("quant_0x18", 64'(features[3:0]), 64'(q18_exp));
        check("quant_0xF8", 64'(features[7:4]), 64'hF);
        expect_result(0);

        // Early s_last on beat 5, then a good frame with input gaps.
        send_frame(5, 4, -1, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_m_valid_early_last", 64'(m_valid), 64'd0);
        end
        send_frame(12, 11, -1, 1);
        expect_result(0);

        // Missing s_last on beat 12, then a good frame.
        send_frame(12, -1, -1, 0);
        send_frame(12, 11, -1, 0);
        expect_result(0);

        // Output backpressure for 10 cycles.
        m_ready = 1'b0;
        send_frame(12, 11, -1, 1);
        expect_result(10);

        // Reset while settling aborts the frame.
        send_frame(12, 11, -1, 0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_m_valid", 64'(m_valid), 64'd0);
        check("mid_rst_features", 64'(features), 64'd0);
        check("mid_rst_m_class", 64'(m_class), 64'd0);
        check("mid_rst_frame_err", 64'(frame_err), 64'd0);
        check("mid_rst_s_ready", 64'(s_ready), 64'd1);
        tick(2);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("no_stray_m_valid", 64'(m_valid), 64'd0);
        end
        exp_idx = 0;
        send_frame(12, 11, -1, 0);
        expect_result(0);

        // Randomized frames with gaps and random backpressure.
        for (int f = 0; f < 4; f++) begin
            int bp = $urandom_range(0, 3);
            m_ready = (bp == 0);
            send_frame(12, 11, -1, 1);
            expect_result(bp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
